// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared definitions for the memory-mapped UART controller.
// Contents: register byte offsets, CON bit positions, TX/RX FSM state enums
// and the baud divider helper.
package uart_ctrl_pkg;

  // Register byte offsets; addr[3:2] selects the register.
  localparam logic [3:0] TxdOffset = 4'h0;
  localparam logic [3:0] RxdOffset = 4'h4;
  localparam logic [3:0] ConOffset = 4'h8;

  // CON register bit positions
  localparam int unsigned ConTxIntEn  = 0;
  localparam int unsigned ConRxIntEn  = 1;
  localparam int unsigned ConTxDone   = 2;
  localparam int unsigned ConRxValid  = 3;
  localparam int unsigned ConTxBusy   = 4;
  localparam int unsigned ConRxOvr    = 5;
  localparam int unsigned ConFrameErr = 6;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // Clock cycles per bit, truncated.
  function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: receive path of the UART controller.
// Synchronizes the asynchronous serial input, detects the start edge, samples
// the 8 data bits (LSB first) and the stop bit at bit midpoints.
// Ports:
//   sysclk, reset      - clock, synchronous active-high reset
//   uart_rx            - asynchronous serial input, idle high
//   byte_strobe        - 1-cycle pulse: a byte with a valid stop bit arrived
//   rx_byte            - received byte, stable while byte_strobe is high
//   frame_err_strobe   - 1-cycle pulse: stop bit sampled as 0, byte dropped
module uart_rx_engine
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned DIV = 16  // cycles per bit, must be >= 2
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       byte_strobe,
  output logic [7:0] rx_byte,
  output logic       frame_err_strobe
);

  localparam int unsigned CntW = (DIV > 2) ? $clog2(DIV) : 1;

  logic            sync1_q, sync2_q, prev_q;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            bit_end, half_bit;

  assign bit_end  = (cnt_q == CntW'(DIV - 1));
  assign half_bit = (cnt_q == CntW'(DIV / 2 - 1));
  assign rx_byte  = shift_q;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      // Line idles high; preset so reset release is not seen as a start edge.
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RxIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q + CntW'(1);
    bit_d            = bit_q;
    shift_d          = shift_q;
    byte_strobe      = 1'b0;
    frame_err_strobe = 1'b0;
    unique case (state_q)
      RxIdle: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = RxStart;
      end
      RxStart: begin
        // Re-check the line half a bit in; a high level means a glitch.
        if (half_bit) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RxStop;
        end
      end
      RxStop: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = RxIdle;
          if (sync2_q) byte_strobe = 1'b1;
          else         frame_err_strobe = 1'b1;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: memory-mapped UART controller for the peripheral bus.
// Holds the TX FSM, the TXD/RXD/CON register file and the interrupt logic;
// the receive path lives in uart_rx_engine.
// Ports:
//   sysclk, reset   - clock, synchronous active-high reset
//   addr            - byte offset, addr[3:2] selects TXD/RXD/CON/reserved
//   rd_en, wr_en    - bus strobes; rd_en on RXD consumes the received byte
//   wdata, rdata    - bus write data / combinational read data
//   irq             - level interrupt: TX done or RX valid, each gated by enable
//   uart_rx         - serial input (asynchronous)
//   uart_tx         - serial output (registered, idle high)
module uart_mmio_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [3:0]  addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int unsigned Div  = uart_div(CLK_HZ, BAUD);
  localparam int unsigned CntW = (Div > 2) ? $clog2(Div) : 1;

  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic            tx_line_q, tx_line_d;
  logic [7:0]      txd_q, txd_d, rxd_q, rxd_d;
  logic            tx_int_en_q, tx_int_en_d, rx_int_en_q, rx_int_en_d;
  logic            tx_done_q, tx_done_d, rx_valid_q, rx_valid_d;
  logic            rx_ovr_q, rx_ovr_d, frame_err_q, frame_err_d;

  logic       tx_bit_end, tx_finish, tx_busy;
  logic       wr_txd, wr_con, rd_rxd;
  logic       byte_strobe, frame_err_strobe;
  logic [7:0] rx_byte;
  logic       unused_bits;

  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  assign wr_txd     = wr_en && (addr[3:2] == TxdOffset[3:2]);
  assign wr_con     = wr_en && (addr[3:2] == ConOffset[3:2]);
  assign rd_rxd     = rd_en && (addr[3:2] == RxdOffset[3:2]);
  assign tx_busy    = (tx_state_q != TxIdle);
  assign tx_bit_end = (tx_cnt_q == CntW'(Div - 1));

  uart_rx_engine #(
    .DIV (Div)
  ) u_rx (
    .sysclk           (sysclk),
    .reset            (reset),
    .uart_rx          (uart_rx),
    .byte_strobe      (byte_strobe),
    .rx_byte          (rx_byte),
    .frame_err_strobe (frame_err_strobe)
  );

  always_ff @(posedge sysclk) begin
    if (reset) begin
      tx_state_q  <= TxIdle;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_line_q   <= 1'b1;
      txd_q       <= '0;
      rxd_q       <= '0;
      tx_int_en_q <= 1'b0;
      rx_int_en_q <= 1'b0;
      tx_done_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_ovr_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_line_q   <= tx_line_d;
      txd_q       <= txd_d;
      rxd_q       <= rxd_d;
      tx_int_en_q <= tx_int_en_d;
      rx_int_en_q <= rx_int_en_d;
      tx_done_q   <= tx_done_d;
      rx_valid_q  <= rx_valid_d;
      rx_ovr_q    <= rx_ovr_d;
      frame_err_q <= frame_err_d;
    end
  end

  // TX FSM: each state is held for Div cycles; the line is registered so the
  // next bit value is computed one state ahead.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_bit_end ? '0 : tx_cnt_q + CntW'(1);
    tx_bit_d   = tx_bit_q;
    tx_line_d  = tx_line_q;
    txd_d      = txd_q;
    tx_finish  = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        tx_cnt_d = '0;
        // Writes while busy fall through here untouched.
        if (wr_txd) begin
          txd_d      = wdata[7:0];
          tx_line_d  = 1'b0;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        if (tx_bit_end) begin
          tx_bit_d   = '0;
          tx_line_d  = txd_q[0];
          tx_state_d = TxData;
        end
      end
      TxData: begin
        if (tx_bit_end) begin
          if (tx_bit_q == 3'd7) begin
            tx_line_d  = 1'b1;
            tx_state_d = TxStop;
          end else begin
            tx_bit_d  = tx_bit_q + 3'd1;
            tx_line_d = txd_q[tx_bit_q + 3'd1];
          end
        end
      end
      TxStop: begin
        if (tx_bit_end) begin
          tx_finish  = 1'b1;
          tx_state_d = TxIdle;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  // Flag updates: later assignments take priority, so hardware sets beat W1C
  // and an RX completion beats a same-edge RXD read.
  always_comb begin
    tx_int_en_d = tx_int_en_q;
    rx_int_en_d = rx_int_en_q;
    tx_done_d   = tx_done_q;
    rx_valid_d  = rx_valid_q;
    rx_ovr_d    = rx_ovr_q;
    frame_err_d = frame_err_q;
    rxd_d       = rxd_q;
    if (wr_con) begin
      tx_int_en_d = wdata[ConTxIntEn];
      rx_int_en_d = wdata[ConRxIntEn];
      if (wdata[ConTxDone])   tx_done_d   = 1'b0;
      if (wdata[ConRxOvr])    rx_ovr_d    = 1'b0;
      if (wdata[ConFrameErr]) frame_err_d = 1'b0;
    end
    if (rd_rxd) rx_valid_d = 1'b0;
    if (tx_finish) tx_done_d = 1'b1;
    if (byte_strobe) begin
      if (!rx_valid_q || rd_rxd) begin
        rxd_d      = rx_byte;
        rx_valid_d = 1'b1;
      end else begin
        rx_ovr_d = 1'b1;
      end
    end
    if (frame_err_strobe) frame_err_d = 1'b1;
  end

  always_comb begin
    rdata = '0;
    case (addr[3:2])
      TxdOffset[3:2]: rdata[7:0] = txd_q;
      RxdOffset[3:2]: rdata[7:0] = rxd_q;
      ConOffset[3:2]: begin
        rdata[ConTxIntEn]  = tx_int_en_q;
        rdata[ConRxIntEn]  = rx_int_en_q;
        rdata[ConTxDone]   = tx_done_q;
        rdata[ConRxValid]  = rx_valid_q;
        rdata[ConTxBusy]   = tx_busy;
        rdata[ConRxOvr]    = rx_ovr_q;
        rdata[ConFrameErr] = frame_err_q;
      end
      default: rdata = '0;
    endcase
  end

  assign irq     = (tx_int_en_q & tx_done_q) | (rx_int_en_q & rx_valid_q);
  assign uart_tx = tx_line_q;

endmodule
